// File: rtl/btn_debounce.sv
// btn_debounce: per-channel 2-flop synchroniser, debouncer and press/release/long-press pulse generator
module btn_debounce #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int LONG_CYCLES     = 6000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_BTN-1:0] BTN_RAW,
    output logic [NUM_BTN-1:0] BTN_PRESSED,
    output logic [NUM_BTN-1:0] BTN_PRESS_P,
    output logic [NUM_BTN-1:0] BTN_RELEASE_P,
    output logic [NUM_BTN-1:0] BTN_LONG_P
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    typedef enum logic [1:0] {RELEASED, HELD, LONG_HELD} state_t;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic          sync1, sync2, prs, prs_p, rel_p, lng_p;
        logic          s, acc, prs_nx, press_nx, rel_nx, long_nx;
        logic [DW-1:0] dcnt, dcnt_nx;
        logic [HW-1:0] hcnt, hcnt_nx;
        state_t        st, st_nx;

        always_comb begin
            s        = sync2 ^ BTN_ACTIVE_LOW;
            acc      = (s != prs) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
            dcnt_nx  = (s == prs || acc) ? '0 : dcnt + DW'(1);
            prs_nx   = acc ? s : prs;
            press_nx = acc & s;
            rel_nx   = acc & ~s;
            st_nx    = st;
            hcnt_nx  = hcnt;
            long_nx  = 1'b0;
            case (st)
                RELEASED: if (press_nx) begin
                    st_nx   = HELD;
                    hcnt_nx = '0;
                end
                // a release accepted on the expiry cycle takes priority over the long pulse
                HELD: if (rel_nx) st_nx = RELEASED;
                    else if (hcnt == HW'(LONG_CYCLES - 1)) begin
                        st_nx   = LONG_HELD;
                        long_nx = 1'b1;
                    end else hcnt_nx = hcnt + HW'(1);
                LONG_HELD: if (rel_nx) st_nx = RELEASED;
                default: st_nx = RELEASED;
            endcase
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sync1 <= BTN_ACTIVE_LOW;
                sync2 <= BTN_ACTIVE_LOW;
                dcnt  <= '0;
                hcnt  <= '0;
                prs   <= 1'b0;
                prs_p <= 1'b0;
                rel_p <= 1'b0;
                lng_p <= 1'b0;
                st    <= RELEASED;
            end else begin
                sync1 <= BTN_RAW[i];
                sync2 <= sync1;
                dcnt  <= dcnt_nx;
                hcnt  <= hcnt_nx;
                prs   <= prs_nx;
                prs_p <= press_nx;
                rel_p <= rel_nx;
                lng_p <= long_nx;
                st    <= st_nx;
            end
        end

        assign BTN_PRESSED[i]   = prs;
        assign BTN_PRESS_P[i]   = prs_p;
        assign BTN_RELEASE_P[i] = rel_p;
        assign BTN_LONG_P[i]    = lng_p;
    end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed table-driven bench with hand-computed expectations for btn_debounce
module tb_btn_debounce;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic [3:0] BTN_RAW = 4'b0000;
    logic [3:0] BTN_PRESSED, BTN_PRESS_P, BTN_RELEASE_P, BTN_LONG_P;
    int nvec = 0;
    int nbad = 0;

    btn_debounce #(.NUM_BTN(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .BTN_ACTIVE_LOW(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .BTN_RAW(BTN_RAW),
        .BTN_PRESSED(BTN_PRESSED), .BTN_PRESS_P(BTN_PRESS_P),
        .BTN_RELEASE_P(BTN_RELEASE_P), .BTN_LONG_P(BTN_LONG_P)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] raw;
        int         reps;
        logic [3:0] prs, prp, rlp, lgp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic [3:0] raw, int reps, logic [3:0] prs, logic [3:0] prp,
                               logic [3:0] rlp, logic [3:0] lgp);
        vec_t r;
        r.raw = raw; r.reps = reps; r.prs = prs; r.prp = prp; r.rlp = rlp; r.lgp = lgp;
        return r;
    endfunction

    task automatic check(string nm, int idx, logic [15:0] exp);
        logic [15:0] got;
        got = {BTN_PRESSED, BTN_PRESS_P, BTN_RELEASE_P, BTN_LONG_P};
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s #%0d: {pressed,press,release,long} got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic step(logic [3:0] raw);
        BTN_RAW = raw;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset phase: all pads pressed while in reset; sync flops start at released level
        tbl.push_back(v(4'b0000, 5, 4'h0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b0000, 1, 4'hF, 4'hF, 4'h0, 4'h0));
        tbl.push_back(v(4'b1111, 5, 4'hF, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1111, 1, 4'h0, 4'h0, 4'hF, 4'h0));
        tbl.push_back(v(4'b1111, 2, 4'h0, 4'h0, 4'h0, 4'h0));
        // Clean press/release on ch0
        tbl.push_back(v(4'b1110, 5, 4'h0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1110, 1, 4'h1, 4'h1, 4'h0, 4'h0));
        tbl.push_back(v(4'b1111, 5, 4'h1, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1111, 1, 4'h0, 4'h0, 4'h1, 4'h0));
        tbl.push_back(v(4'b1111, 2, 4'h0, 4'h0, 4'h0, 4'h0));
        // Bounce on ch1: low 3, high 1, then steady low
        tbl.push_back(v(4'b1101, 3, 4'h0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1111, 1, 4'h0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1101, 5, 4'h0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1101, 1, 4'h2, 4'h2, 4'h0, 4'h0));
        tbl.push_back(v(4'b1101, 2, 4'h2, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1111, 5, 4'h2, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1111, 1, 4'h0, 4'h0, 4'h2, 4'h0));
        tbl.push_back(v(4'b1111, 2, 4'h0, 4'h0, 4'h0, 4'h0));
        // Long press on ch2: held 40 cycles, long pulse 20 cycles after press
        tbl.push_back(v(4'b1011, 5, 4'h0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1011, 1, 4'h4, 4'h4, 4'h0, 4'h0));
        tbl.push_back(v(4'b1011, 19, 4'h4, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1011, 1, 4'h4, 4'h0, 4'h0, 4'h4));
        tbl.push_back(v(4'b1011, 14, 4'h4, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1111, 5, 4'h4, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1111, 1, 4'h0, 4'h0, 4'h4, 4'h0));
        tbl.push_back(v(4'b1111, 2, 4'h0, 4'h0, 4'h0, 4'h0));
        // Race on ch3: release accepted exactly when the long count expires
        tbl.push_back(v(4'b0111, 5, 4'h0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b0111, 1, 4'h8, 4'h8, 4'h0, 4'h0));
        tbl.push_back(v(4'b0111, 14, 4'h8, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1111, 5, 4'h8, 4'h0, 4'h0, 4'h0));
        tbl.push_back(v(4'b1111, 1, 4'h0, 4'h0, 4'h8, 4'h0));
        tbl.push_back(v(4'b1111, 3, 4'h0, 4'h0, 4'h0, 4'h0));

        #2 RST_N = 1'b0;
        #1 check("reset_async", 0, 16'h0000);
        repeat (3) @(posedge CLK);
        #1 check("reset_held", 0, 16'h0000);
        RST_N = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            for (int n = 0; n < tbl[i].reps; n++) begin
                step(tbl[i].raw);
                check("table", i, {tbl[i].prs, tbl[i].prp, tbl[i].rlp, tbl[i].lgp});
            end

        // Reset mid-HELD on ch3, taken while PRESS_P is high, then re-press after reset
        for (int n = 0; n < 5; n++) begin
            step(4'b0111);
            check("mid_press_wait", n, 16'h0000);
        end
        step(4'b0111);
        check("mid_press_accept", 0, 16'h8800);
        #2 RST_N = 1'b0;
        #1 check("mid_reset_async", 0, 16'h0000);
        @(posedge CLK);
        #1 check("mid_reset_held", 0, 16'h0000);
        RST_N = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step(4'b0111);
            check("repress_wait", n, 16'h0000);
        end
        step(4'b0111);
        check("repress_accept", 0, 16'h8800);
        step(4'b0111);
        check("repress_hold", 0, 16'h8000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
